// File: rtl/pattern_gen.sv
// Burst pattern generator: emits DEPTH beats of a CONST/INCR/WALK/ALT pattern
// over a valid/ready stream, then pulses done for one cycle.
module pattern_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(4'h5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [1:0]       mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [KW-1:0]    k_inc;

  function automatic logic [WIDTH-1:0] first_beat(input logic [1:0] m);
    first_beat = (m == MODE_WALK) ? WIDTH'(1) : INIT;
  endfunction

  // Each beat is derived from the previous one, so no divider is needed for WALK.
  function automatic logic [WIDTH-1:0] next_beat(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] cur);
    case (m)
      MODE_CONST: next_beat = cur;
      MODE_INCR:  next_beat = cur + WIDTH'(1);
      MODE_WALK:  next_beat = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ALT:   next_beat = ~cur;
      default:    next_beat = cur;
    endcase
  endfunction

  assign k_inc = k_q + KW'(1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          k_d     = '0;
          valid_d = 1'b1;
          data_d  = first_beat(mode);
          last_d  = (K_LAST == '0);
        end
      end
      S_RUN: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
            k_d     = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            done_d  = 1'b1;
          end else begin
            k_d    = k_inc;
            data_d = next_beat(mode_q, data_q);
            last_d = (k_inc == K_LAST);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      mode_q  <= MODE_CONST;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: default instance, an INIT=E instance for the
// INCR wrap case, and a DEPTH=1 instance for the single-beat boundary.
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  int         n_cmp = 0;
  int         n_err = 0;

  // Default instance (WIDTH=4, DEPTH=8, INIT=5)
  logic       start, ready, v, l, b, d;
  logic [1:0] mode;
  logic [3:0] data;
  // INIT=E instance
  logic       start_e, ready_e, v_e, l_e, b_e, d_e;
  logic [1:0] mode_e;
  logic [3:0] data_e;
  // DEPTH=1 instance
  logic       start_1, ready_1, v_1, l_1, b_1, d_1;
  logic [1:0] mode_1;
  logic [3:0] data_1;

  logic [7:0] got, exp;

  always #5 clk = ~clk;

  pattern_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .out_valid(v),
    .out_ready(ready), .out_data(data), .out_last(l), .busy(b), .done(d)
  );

  pattern_gen #(.WIDTH(4), .DEPTH(8), .INIT(4'hE)) u_dut_e (
    .clk(clk), .rst(rst), .start(start_e), .mode(mode_e), .out_valid(v_e),
    .out_ready(ready_e), .out_data(data_e), .out_last(l_e), .busy(b_e), .done(d_e)
  );

  pattern_gen #(.WIDTH(4), .DEPTH(1), .INIT(4'h5)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_1), .mode(mode_1), .out_valid(v_1),
    .out_ready(ready_1), .out_data(data_1), .out_last(l_1), .busy(b_1), .done(d_1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Vectors below are {valid, last, busy, done, data[3:0]}.
  task automatic test_reset;
    rst = 1'b1; start = 1'b1; mode = 2'd0;
    tick();
    got = {v, l, b, d, data}; exp = 8'h00; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_vs_start got %b expected %b", got, exp); end
    got = {v_e, l_e, b_e, d_e, data_e}; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_e got %b expected %b", got, exp); end
    rst = 1'b0; start = 1'b0;
    tick();
    got = {v, l, b, d, data}; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_idle got %b expected %b", got, exp); end
  endtask

  task automatic test_const;
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {v, l, b, d, data}; exp = {1'b1, i == 7, 1'b1, 1'b0, 4'h5}; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL const beat %0d got %b expected %b", i, got, exp); end
      tick();
    end
    got = {v, l, b, d, data}; exp = 8'b0011_0000; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL const done got %b expected %b", got, exp); end
    tick();
    got = {v, l, b, d, data}; exp = 8'h00; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL const idle got %b expected %b", got, exp); end
  endtask

  task automatic test_incr_wrap;
    logic [3:0] e;
    start_e = 1'b1; mode_e = 2'd1;
    tick();
    start_e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = 4'(14 + i);
      got = {v_e, l_e, b_e, d_e, data_e}; exp = {1'b1, i == 7, 1'b1, 1'b0, e}; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL incr_wrap beat %0d got %b expected %b", i, got, exp); end
      tick();
    end
    got = {v_e, l_e, b_e, d_e, data_e}; exp = 8'b0011_0000; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL incr_wrap done got %b expected %b", got, exp); end
    tick();
  endtask

  task automatic test_walk_alt;
    logic [3:0] e;
    for (int m = 2; m <= 3; m++) begin
      start = 1'b1; mode = 2'(m);
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (m == 2) e = 4'b0001 << (i % 4);
        else        e = (i % 2 == 0) ? 4'h5 : 4'hA;
        got = {v, l, b, d, data}; exp = {1'b1, i == 7, 1'b1, 1'b0, e}; n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mode%0d beat %0d got %b expected %b", m, i, got, exp); end
        tick();
      end
      got = {v, l, b, d, data}; exp = 8'b0011_0000; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL mode%0d done got %b expected %b", m, got, exp); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    start = 1'b1; mode = 2'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          got = {v, l, b, d, data}; exp = {4'b1010, 4'h7}; n_cmp++;
          if (got !== exp) begin n_err++; $display("FAIL stall cycle %0d got %b expected %b", s, got, exp); end
          tick();
        end
        ready = 1'b1;
      end
      got = {v, l, b, d, data}; exp = {1'b1, i == 7, 1'b1, 1'b0, 4'(5 + i)}; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL bp beat %0d got %b expected %b", i, got, exp); end
      tick();
    end
    got = {v, l, b, d, data}; exp = 8'b0011_0000; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL bp done got %b expected %b", got, exp); end
    tick();
  endtask

  task automatic test_midburst_inputs;
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin start = 1'b1; mode = 2'd2; end
      if (i == 4) start = 1'b0;
      got = {v, l, b, d, data}; exp = {1'b1, i == 7, 1'b1, 1'b0, 4'h5}; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL midburst beat %0d got %b expected %b", i, got, exp); end
      tick();
    end
    tick();
    mode = 2'd0;
    tick();
    got = {v, l, b, d, data}; exp = 8'h00; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL midburst no_restart got %b expected %b", got, exp); end
  endtask

  task automatic test_reset_midburst;
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    got = {v, l, b, d, data}; exp = {4'b1010, 4'h5}; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL pre_rst beat3 got %b expected %b", got, exp); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp = 8'h00;
    for (int s = 0; s < 2; s++) begin
      got = {v, l, b, d, data}; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL post_rst cycle %0d got %b expected %b", s, got, exp); end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {v, l, b, d, data}; exp = {1'b1, i == 7, 1'b1, 1'b0, 4'h5}; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL restart beat %0d got %b expected %b", i, got, exp); end
      tick();
    end
    got = {v, l, b, d, data}; exp = 8'b0011_0000; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL restart done got %b expected %b", got, exp); end
  endtask

  // Entered with the default instance in DONE; start held across DONE and IDLE.
  task automatic test_back_to_back;
    start = 1'b1; mode = 2'd1;
    tick();
    got = {v, l, b, d, data}; exp = 8'h00; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL b2b idle_gap got %b expected %b", got, exp); end
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {v, l, b, d, data}; exp = {1'b1, i == 7, 1'b1, 1'b0, 4'(5 + i)}; n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL b2b beat %0d got %b expected %b", i, got, exp); end
      tick();
    end
    got = {v, l, b, d, data}; exp = 8'b0011_0000; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL b2b done got %b expected %b", got, exp); end
    tick();
  endtask

  task automatic test_depth1;
    start_1 = 1'b1; mode_1 = 2'd0;
    tick();
    start_1 = 1'b0;
    got = {v_1, l_1, b_1, d_1, data_1}; exp = {4'b1110, 4'h5}; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL depth1 beat got %b expected %b", got, exp); end
    tick();
    got = {v_1, l_1, b_1, d_1, data_1}; exp = 8'b0011_0000; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL depth1 done got %b expected %b", got, exp); end
    tick();
    got = {v_1, l_1, b_1, d_1, data_1}; exp = 8'h00; n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL depth1 idle got %b expected %b", got, exp); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;   mode = 2'd0;   ready = 1'b1;
    start_e = 1'b0; mode_e = 2'd0; ready_e = 1'b1;
    start_1 = 1'b0; mode_1 = 2'd0; ready_1 = 1'b1;
    test_reset();
    test_const();
    test_incr_wrap();
    test_walk_alt();
    test_backpressure();
    test_midburst_inputs();
    test_reset_midburst();
    test_back_to_back();
    test_depth1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
